// File: rtl/alu_operand_stage.sv
// ID/EX stage in front of the ALU: registers the decoded instruction, resolves
// forwarded/immediate operands and the 3-bit ALU function behind a valid/ready handshake.
module alu_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_rd1,
  input  logic [WIDTH-1:0]   in_rd2,
  input  logic [REGBITS-1:0] in_rs,
  input  logic [REGBITS-1:0] in_rt,
  input  logic [REGBITS-1:0] in_dst,
  input  logic [15:0]        in_imm,
  input  logic               in_alusrc,
  input  logic               in_zext,
  input  logic [1:0]         in_aluop,
  input  logic [5:0]         in_funct,
  input  logic               exm_wr,
  input  logic [REGBITS-1:0] exm_rd,
  input  logic [WIDTH-1:0]   exm_val,
  input  logic               mwb_wr,
  input  logic [REGBITS-1:0] mwb_rd,
  input  logic [WIDTH-1:0]   mwb_val,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_A,
  output logic [WIDTH-1:0]   out_b,
  output logic [2:0]         out_F,
  output logic [WIDTH-1:0]   out_sdata,
  output logic [REGBITS-1:0] out_dst,
  output logic               out_illegal
);

  logic               valid_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, sdata_reg;
  logic [2:0]         f_reg;
  logic [REGBITS-1:0] dst_reg;
  logic               illegal_reg;

  logic               capture;
  logic [1:0][REGBITS-1:0] src_sel;
  logic [1:0][WIDTH-1:0]   rf_data;
  logic [1:0][WIDTH-1:0]   fwd_val;
  logic [WIDTH-1:0]   imm_ext;
  logic [WIDTH-1:0]   b_next;
  logic [2:0]         f_next;
  logic               illegal_next;

  assign in_ready = !valid_reg | out_ready;
  assign capture  = in_valid & in_ready & !flush;

  assign src_sel[0] = in_rs;
  assign src_sel[1] = in_rt;
  assign rf_data[0] = in_rd1;
  assign rf_data[1] = in_rd2;

  // Index 0 resolves rs, index 1 resolves rt; EX/MEM wins over MEM/WB, r0 never forwards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_val[gi] =
        (exm_wr && (exm_rd == src_sel[gi]) && (src_sel[gi] != '0)) ? exm_val :
        (mwb_wr && (mwb_rd == src_sel[gi]) && (src_sel[gi] != '0)) ? mwb_val :
        rf_data[gi];
    end
  endgenerate

  assign imm_ext = in_zext ? {{(WIDTH-16){1'b0}}, in_imm}
                           : {{(WIDTH-16){in_imm[15]}}, in_imm};
  assign b_next  = in_alusrc ? imm_ext : fwd_val[1];

  always_comb begin
    f_next       = 3'b010;
    illegal_next = 1'b0;
    case (in_aluop)
      2'b00: f_next = 3'b010;
      2'b01: f_next = 3'b110;
      default: begin
        case (in_funct)
          6'b100000: f_next = 3'b010;
          6'b100010: f_next = 3'b110;
          6'b100100: f_next = 3'b000;
          6'b100101: f_next = 3'b001;
          6'b101010: f_next = 3'b111;
          default:   illegal_next = 1'b1;
        endcase
      end
    endcase
  end

  // Flush beats capture and stall; the payload simply holds when not capturing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sdata_reg   <= '0;
      f_reg       <= '0;
      dst_reg     <= '0;
      illegal_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (capture) begin
      valid_reg   <= 1'b1;
      a_reg       <= fwd_val[0];
      b_reg       <= b_next;
      sdata_reg   <= fwd_val[1];
      f_reg       <= f_next;
      dst_reg     <= in_dst;
      illegal_reg <= illegal_next;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid   = valid_reg;
  assign out_A       = a_reg;
  assign out_b       = b_reg;
  assign out_sdata   = sdata_reg;
  assign out_F       = f_reg;
  assign out_dst     = dst_reg;
  assign out_illegal = illegal_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_rd1, in_rd2;
  logic [4:0]  in_rs, in_rt, in_dst;
  logic [15:0] in_imm;
  logic        in_alusrc, in_zext;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic        exm_wr, mwb_wr;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_val, mwb_val;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_A, out_b, out_sdata;
  logic [2:0]  out_F;
  logic [4:0]  out_dst;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst),
    .in_imm(in_imm), .in_alusrc(in_alusrc), .in_zext(in_zext),
    .in_aluop(in_aluop), .in_funct(in_funct),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_val(exm_val),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_b(out_b), .out_F(out_F), .out_sdata(out_sdata),
    .out_dst(out_dst), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (exm_wr && exm_rd == r) return exm_val;
    if (mwb_wr && mwb_rd == r) return mwb_val;
    return rf;
  endfunction

  // returns {illegal, F}
  function automatic logic [3:0] ref_func(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (fn)
      6'd32:   return 4'b0010;
      6'd34:   return 4'b0110;
      6'd36:   return 4'b0000;
      6'd37:   return 4'b0001;
      6'd42:   return 4'b0111;
      default: return 4'b1010;
    endcase
  endfunction

  logic        m_valid = 0, m_ill = 0;
  logic [31:0] m_A = 0, m_b = 0, m_sdata = 0;
  logic [2:0]  m_F = 0;
  logic [4:0]  m_dst = 0;

  always @(posedge clk or posedge reset) begin
    logic [3:0]  fi;
    logic [31:0] imm32;
    if (reset) begin
      m_valid <= 0; m_A <= 0; m_b <= 0; m_sdata <= 0; m_F <= 0; m_dst <= 0; m_ill <= 0;
    end else if (flush) begin
      m_valid <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      fi    = ref_func(in_aluop, in_funct);
      imm32 = in_zext ? 32'(in_imm) : 32'(signed'(in_imm));
      m_valid <= 1;
      m_A     <= ref_operand(in_rs, in_rd1);
      m_sdata <= ref_operand(in_rt, in_rd2);
      m_b     <= in_alusrc ? imm32 : ref_operand(in_rt, in_rd2);
      m_F     <= fi[2:0];
      m_ill   <= fi[3];
      m_dst   <= in_dst;
    end else if (out_ready) begin
      m_valid <= 0;
    end
  end

  always @(negedge clk) begin
    check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
    check("cmp_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    if (m_valid) begin
      check("cmp_out_A", out_A, m_A);
      check("cmp_out_b", out_b, m_b);
      check("cmp_out_sdata", out_sdata, m_sdata);
      check("cmp_out_F", 32'(out_F), 32'(m_F));
      check("cmp_out_dst", 32'(out_dst), 32'(m_dst));
      check("cmp_out_illegal", 32'(out_illegal), 32'(m_ill));
    end
  end

  // Inputs change only 3 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_rd1 = 0; in_rd2 = 0; in_rs = 0; in_rt = 0; in_dst = 0;
    in_imm = 0; in_alusrc = 0; in_zext = 0; in_aluop = 0; in_funct = 0;
    exm_wr = 0; exm_rd = 0; exm_val = 0; mwb_wr = 0; mwb_rd = 0; mwb_val = 0;
    flush = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_F", 32'(out_F), 0);
    check("reset_out_illegal", 32'(out_illegal), 0);
    check("reset_in_ready", 32'(in_ready), 1);

    // slt, no forwarding
    in_rs = 1; in_rt = 2; in_rd1 = 5; in_rd2 = 9; in_aluop = 2'b10; in_funct = 6'b101010;
    in_dst = 7; in_valid = 1;
    tick();
    check("slt_valid", 32'(out_valid), 1);
    check("slt_A", out_A, 5);
    check("slt_b", out_b, 9);
    check("slt_F", 32'(out_F), 3'b111);

    // forwarding priority, then r0 never forwarded
    in_rs = 3; in_rd1 = 32'h11;
    exm_wr = 1; exm_rd = 3; exm_val = 32'hAA; mwb_wr = 1; mwb_rd = 3; mwb_val = 32'hBB;
    tick();
    check("fwd_exm_A", out_A, 32'hAA);
    in_rs = 0; in_rd1 = 32'h22; exm_rd = 0; mwb_rd = 0;
    tick();
    check("fwd_r0_A", out_A, 32'h22);
    exm_wr = 0; mwb_wr = 0;

    // immediate extension
    in_alusrc = 1; in_imm = 16'h8001; in_zext = 0;
    tick();
    check("imm_sext_b", out_b, 32'hFFFF8001);
    in_zext = 1;
    tick();
    check("imm_zext_b", out_b, 32'h00008001);
    in_alusrc = 0; in_zext = 0;

    // stall for three cycles while a second instruction waits
    in_rs = 4; in_rt = 5; in_rd1 = 32'h100; in_rd2 = 32'h200; in_aluop = 2'b00;
    tick();
    out_ready = 0;
    in_rd1 = 32'h300; in_rd2 = 32'h400; in_aluop = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_A", out_A, 32'h100);
      check("stall_b", out_b, 32'h200);
      check("stall_F", 32'(out_F), 3'b010);
    end
    out_ready = 1;
    #1 check("unstall_in_ready", 32'(in_ready), 1);
    tick();
    check("unstall_A", out_A, 32'h300);
    check("unstall_F", 32'(out_F), 3'b110);

    // flush with an incoming instruction
    flush = 1;
    tick();
    check("flush_valid", 32'(out_valid), 0);
    flush = 0;

    // unknown funct
    in_aluop = 2'b10; in_funct = 6'b000111;
    tick();
    check("illegal_flag", 32'(out_illegal), 1);
    check("illegal_F", 32'(out_F), 3'b010);

    // asynchronous reset while stalled
    in_valid = 1; in_aluop = 2'b00; out_ready = 0;
    tick();
    check("pre_reset_valid", 32'(out_valid), 1);
    #1 reset = 1;
    #1;
    check("async_reset_valid", 32'(out_valid), 0);
    check("async_reset_F", 32'(out_F), 0);
    check("async_reset_in_ready", 32'(in_ready), 1);
    #3 reset = 0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_rs     = 5'($urandom_range(0, 3));
      in_rt     = 5'($urandom_range(0, 3));
      in_dst    = 5'($urandom);
      in_rd1    = $urandom;
      in_rd2    = $urandom;
      in_imm    = 16'($urandom);
      in_alusrc = 1'($urandom);
      in_zext   = 1'($urandom);
      in_aluop  = 2'($urandom);
      case ($urandom_range(0, 5))
        0: in_funct = 6'd32;
        1: in_funct = 6'd34;
        2: in_funct = 6'd36;
        3: in_funct = 6'd37;
        4: in_funct = 6'd42;
        default: in_funct = 6'($urandom);
      endcase
      exm_wr  = 1'($urandom);
      exm_rd  = 5'($urandom_range(0, 3));
      exm_val = $urandom;
      mwb_wr  = 1'($urandom);
      mwb_rd  = 5'($urandom_range(0, 3));
      mwb_val = $urandom;
    end
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
